// File: rtl/ram_arbiter_pkg.sv
// Shared FSM state encoding and port indices for ram_arbiter.
// Round-robin tie-break is enabled with RAM_ARB_ROUND_ROBIN_EN.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_ACK   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;
  localparam logic PTR_RST  = PORT_VID;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between the CPU and video requesters.
// RAM_ARB_ROUND_ROBIN_EN: ties go to the port that did not win last.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic any,
  output logic winner
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    any    = req0 | req1;
    winner = PORT_CPU;
    if (req0 && req1)
      winner = ~ptr;
    else if (req1)
      winner = PORT_VID;
  end
`else
  logic ptr_unused;
  assign ptr_unused = ptr;

  always_comb begin
    any    = req0 | req1;
    winner = PORT_CPU;
    if (!req0 && req1)
      winner = PORT_VID;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter in front of a single-port async-read ram.
// Tie policy set by RAM_ARB_ROUND_ROBIN_EN (see ram_arb_pick).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [DEPTH-1:0] addr0,
  input  logic [DEPTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             grant,
  output logic             busy,
  output logic             ram_ena,
  output logic             ram_wena,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  state_e state;
  state_e state_d;

  logic             ptr;
  logic             any;
  logic             winner;
  logic             take;
  logic             serve;
  logic             op_we;
  logic [DEPTH-1:0] op_addr;
  logic [WIDTH-1:0] op_wdata;

  ram_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  assign take  = (state == S_IDLE) && any;
  assign serve = (state == S_SERVE);

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (any) state_d = S_SERVE;
      S_SERVE: state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= PTR_RST;
      grant    <= PORT_CPU;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else begin
      state <= state_d;
      if (take) begin
        op_we    <= winner ? we1 : we0;
        op_addr  <= winner ? addr1 : addr0;
        op_wdata <= winner ? wdata1 : wdata0;
        grant    <= winner;
        ptr      <= winner;
      end
      ack0 <= serve && (grant == PORT_CPU);
      ack1 <= serve && (grant == PORT_VID);
      // Writes leave the last read value visible.
      if (serve && !op_we)
        rdata <= ram_rdata;
    end
  end

  // Gating with rst_n keeps a reset edge from committing a write.
  assign ram_ena   = serve & rst_n;
  assign ram_wena  = serve & op_we;
  assign ram_addr  = op_addr;
  assign ram_wdata = op_wdata;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a bench-side ram.
// Model follows RAM_ARB_ROUND_ROBIN_EN when defined.
module tb_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [2:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, grant, busy;
  logic       ram_ena, ram_wena;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [2:0] ram_addr;

  ram_arbiter #(.WIDTH(8), .DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .grant     (grant),
    .busy      (busy),
    .ram_ena   (ram_ena),
    .ram_wena  (ram_wena),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [8];
  always @(posedge clk)
    if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  typedef struct {
    bit         port;
    logic [7:0] rd;
    int         at;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl_mem [8];
  logic [7:0] mdl_rdata = 8'h00;
  bit         mdl_last = 1'b1;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // One access in completion order: memory effect, held rdata, ack time.
  task automatic model_acc(input bit p, input bit we, input logic [2:0] a,
                           input logic [7:0] d, input int at);
    if (we) mdl_mem[a] = d;
    else mdl_rdata = mdl_mem[a];
    sb.push_back('{p, mdl_rdata, at});
    mdl_last = p;
  endtask

  task automatic round(input bit u0, input bit u1,
                       input bit w0, input logic [2:0] a0, input logic [7:0] d0,
                       input bit w1, input logic [2:0] a1, input logic [7:0] d1);
    int  t0;
    int  n;
    bit  first;
    bit  p0, p1;
    @(negedge clk);
    t0 = cyc;
    chk("busy_at_issue", busy, 0);
    we0 = w0; addr0 = a0; wdata0 = d0; req0 = u0;
    we1 = w1; addr1 = a1; wdata1 = d1; req1 = u1;
    if (u0 && u1) begin
      first = RR ? ~mdl_last : 1'b0;
      if (first) begin
        model_acc(1'b1, w1, a1, d1, t0 + 2);
        model_acc(1'b0, w0, a0, d0, t0 + 5);
      end else begin
        model_acc(1'b0, w0, a0, d0, t0 + 2);
        model_acc(1'b1, w1, a1, d1, t0 + 5);
      end
    end else if (u0) begin
      model_acc(1'b0, w0, a0, d0, t0 + 2);
    end else if (u1) begin
      model_acc(1'b1, w1, a1, d1, t0 + 2);
    end
    p0 = u0; p1 = u1; n = 0;
    while ((p0 || p1) && n < 20) begin
      @(negedge clk);
      n++;
      if (!(u0 && u1)) chk("busy_in_access", busy, 1);
      if (ack0 && p0) begin req0 = 1'b0; p0 = 1'b0; end
      if (ack1 && p1) begin req1 = 1'b0; p1 = 1'b0; end
    end
    chk("round_timeout", {p0, p1}, 0);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Scoreboard monitor: independent of the stimulus process.
  bit prev_ena = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ram_ena) chk("ena_single_cycle", prev_ena, 0);
      prev_ena = ram_ena;
      if (ack0 || ack1) begin
        chk("ack_onehot", ack0 && ack1, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none",
                   ack0, ack1);
        end else begin
          e = sb.pop_front();
          chk("ack_port", ack1, e.port);
          chk("grant", grant, e.port);
          chk("rdata", rdata, e.rd);
          chk("ack_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_ena", ram_ena, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      round(1, 0, 1, 3'(i), 8'(8'h10 + i), 0, 0, 0);

    // Write then read back on port 0.
    round(1, 0, 1, 3'd3, 8'hA5, 0, 0, 0);
    round(1, 0, 0, 3'd3, 8'h00, 0, 0, 0);

    // Read then write: rdata holds through the write ack.
    round(1, 0, 1, 3'd1, 8'h31, 0, 0, 0);
    round(0, 1, 1, 3'd0, 8'h00, 1, 3'd5, 8'h31);
    round(1, 0, 0, 3'd1, 8'h00, 0, 0, 0);
    round(0, 1, 0, 3'd0, 8'h00, 1, 3'd4, 8'h77);

    // Ties: port 1 reads addr 5.
    repeat (4) round(1, 1, 0, 3'd3, 8'h00, 0, 3'd5, 8'h00);

    // Back-to-back on port 0.
    repeat (3) round(1, 0, 0, 3'd4, 8'h00, 0, 0, 0);

    // Reset during SERVE of a write to addr 2.
    @(negedge clk);
    we0 = 1'b1; addr0 = 3'd2; wdata0 = 8'hFF; req0 = 1'b1;
    @(negedge clk);
    chk("abort_in_serve", ram_ena, 1);
    rst_n = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    chk("abort_ack0", ack0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_mem2", mem[2], mdl_mem[2]);
    rst_n = 1'b1;
    mdl_rdata = 8'h00;
    mdl_last = 1'b1;
    round(0, 1, 0, 3'd0, 8'h00, 0, 3'd2, 8'h00);

    // Idle hold.
    repeat (20) begin
      @(negedge clk);
      chk("idle_ena", ram_ena, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ack", {ack0, ack1}, 0);
      chk("idle_rdata", rdata, mdl_rdata);
    end

    repeat (60) begin
      int gap;
      int mode;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      mode = $urandom_range(0, 2);
      round(mode != 1, mode != 0,
            1'($urandom), 3'($urandom), 8'($urandom),
            1'($urandom), 3'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    for (int i = 0; i < 8; i++)
      chk("final_mem", mem[i], mdl_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
